// File: rtl/fetch_queue_unit.sv
// Decoupled instruction-fetch stage: issues i-cache requests, buffers fetched
// {pc, instr} pairs in a circular queue, stops on a halt opcode and flushes on redirect.
module fetch_queue_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter int                DEPTH    = 4,
  parameter int                PC_STEP  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]        HALT_OP  = 4'hF
) (
  input  logic               clk,
  input  logic               rst,
  output logic               icache_req,
  output logic [ADDR_W-1:0]  icache_addr,
  input  logic               icache_ready,
  input  logic [INSTR_W-1:0] icache_data,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               id_ready,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  out_pc_next,
  output logic               fetch_halted
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {FETCH, DROP, HALT} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  fpc;
  logic [ADDR_W-1:0]  drop_addr;
  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic               push;
  logic               pop;
  logic               is_halt;

  // DROP keeps presenting the pre-redirect address until the cache answers it
  assign icache_req  = !rst && ((state == DROP) ||
                                (state == FETCH && count < (PTR_W+1)'(DEPTH)));
  assign icache_addr = (state == DROP) ? drop_addr : fpc;

  assign push    = icache_req && icache_ready && (state == FETCH) && !redirect;
  assign pop     = out_valid && id_ready && !redirect;
  assign is_halt = (icache_data[INSTR_W-1 -: 4] == HALT_OP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FETCH;
      fpc       <= RESET_PC;
      drop_addr <= RESET_PC;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      fpc    <= redirect_pc;
      case (state)
        FETCH: begin
          if (icache_req && !icache_ready) begin
            state     <= DROP;
            drop_addr <= fpc;
          end else begin
            state <= FETCH;
          end
        end
        DROP:    state <= icache_ready ? FETCH : DROP;
        default: state <= FETCH;
      endcase
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        fpc    <= fpc + ADDR_W'(PC_STEP);
        if (is_halt) state <= HALT;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (state == DROP && icache_ready) state <= FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= fpc;
      instr_mem[wr_ptr] <= icache_data;
    end
  end

  assign out_valid    = (count != '0);
  assign out_instr    = instr_mem[rd_ptr];
  assign out_pc       = pc_mem[rd_ptr];
  assign out_pc_next  = out_pc + ADDR_W'(PC_STEP);
  assign fetch_halted = (state == HALT);

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: a simple i-cache model returns 16'h1000+addr,
// optionally a halt word at address 8; each task checks one scenario.
module tb_fetch_queue_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        icache_req;
  logic [15:0] icache_addr;
  logic        icache_ready;
  logic [15:0] icache_data;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        id_ready;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic [15:0] out_pc_next;
  logic        fetch_halted;
  logic        halt_en;

  int checks = 0;
  int fails  = 0;

  fetch_queue_unit dut (
    .clk          (clk),
    .rst          (rst),
    .icache_req   (icache_req),
    .icache_addr  (icache_addr),
    .icache_ready (icache_ready),
    .icache_data  (icache_data),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .id_ready     (id_ready),
    .out_valid    (out_valid),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .out_pc_next  (out_pc_next),
    .fetch_halted (fetch_halted)
  );

  always #5 clk = ~clk;

  assign icache_data = (halt_en && icache_addr == 16'h0008) ? 16'hF000 : 16'h1000 + icache_addr;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
    icache_ready = 1'b0; id_ready = 1'b0; halt_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
    icache_ready = 1'b0; id_ready = 1'b0; halt_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (icache_req !== 1'b0) begin fails++; $display("[TB] FAIL reset_req got=%b exp=0", icache_req); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (fetch_halted !== 1'b0) begin fails++; $display("[TB] FAIL reset_halted got=%b exp=0", fetch_halted); end
    rst = 1'b0;
    #1;
    checks++; if (icache_req !== 1'b1) begin fails++; $display("[TB] FAIL post_reset_req got=%b exp=1", icache_req); end
    checks++; if (icache_addr !== 16'h0000) begin fails++; $display("[TB] FAIL post_reset_addr got=%h exp=0000", icache_addr); end
  endtask

  task automatic test_sequential();
    do_reset();
    icache_ready = 1'b1; id_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL seq_valid[%0d] got=%b exp=1", i, out_valid); end
      checks++; if (out_pc !== 16'(2*i)) begin fails++; $display("[TB] FAIL seq_pc[%0d] got=%h exp=%h", i, out_pc, 16'(2*i)); end
      checks++; if (out_pc_next !== 16'(2*i+2)) begin fails++; $display("[TB] FAIL seq_pc_next[%0d] got=%h exp=%h", i, out_pc_next, 16'(2*i+2)); end
      checks++; if (out_instr !== 16'(16'h1000 + 2*i)) begin fails++; $display("[TB] FAIL seq_instr[%0d] got=%h exp=%h", i, out_instr, 16'(16'h1000 + 2*i)); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    icache_ready = 1'b1; id_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (icache_req !== 1'b1 || icache_addr !== 16'(2*k)) begin
        fails++; $display("[TB] FAIL bp_req[%0d] got req=%b addr=%h exp req=1 addr=%h", k, icache_req, icache_addr, 16'(2*k));
      end
      step();
    end
    checks++; if (icache_req !== 1'b0) begin fails++; $display("[TB] FAIL bp_full_req got=%b exp=0", icache_req); end
    step();
    checks++; if (icache_req !== 1'b0) begin fails++; $display("[TB] FAIL bp_full_hold got=%b exp=0", icache_req); end
    checks++; if (out_pc !== 16'h0000) begin fails++; $display("[TB] FAIL bp_head got=%h exp=0000", out_pc); end
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    checks++; if (out_pc !== 16'h0002) begin fails++; $display("[TB] FAIL bp_pop_head got=%h exp=0002", out_pc); end
    checks++; if (icache_req !== 1'b1 || icache_addr !== 16'h0008) begin
      fails++; $display("[TB] FAIL bp_next_req got req=%b addr=%h exp req=1 addr=0008", icache_req, icache_addr);
    end
  endtask

  task automatic test_miss_stall();
    do_reset();
    icache_ready = 1'b1; id_ready = 1'b0;
    step(); step();
    icache_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++; if (icache_req !== 1'b1 || icache_addr !== 16'h0004) begin
        fails++; $display("[TB] FAIL miss_hold[%0d] got req=%b addr=%h exp req=1 addr=0004", k, icache_req, icache_addr);
      end
      step();
    end
    icache_ready = 1'b1;
    step();
    icache_ready = 1'b0;
    checks++; if (icache_addr !== 16'h0006) begin fails++; $display("[TB] FAIL miss_next_addr got=%h exp=0006", icache_addr); end
    id_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_valid !== 1'b1 || out_pc !== 16'(2*k)) begin
        fails++; $display("[TB] FAIL miss_drain[%0d] got valid=%b pc=%h exp valid=1 pc=%h", k, out_valid, out_pc, 16'(2*k));
      end
      step();
    end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL miss_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_redirect_miss();
    do_reset();
    icache_ready = 1'b1; id_ready = 1'b1;
    step(); step(); step();
    icache_ready = 1'b0;
    checks++; if (icache_addr !== 16'h0006) begin fails++; $display("[TB] FAIL rdm_pending got=%h exp=0006", icache_addr); end
    redirect = 1'b1; redirect_pc = 16'h0040;
    step();
    redirect = 1'b0;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL rdm_flush got=%b exp=0", out_valid); end
    checks++; if (icache_req !== 1'b1 || icache_addr !== 16'h0006) begin
      fails++; $display("[TB] FAIL rdm_drop_hold got req=%b addr=%h exp req=1 addr=0006", icache_req, icache_addr);
    end
    step(); step();
    icache_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL rdm_discard got=%b exp=0", out_valid); end
    checks++; if (icache_req !== 1'b1 || icache_addr !== 16'h0040) begin
      fails++; $display("[TB] FAIL rdm_target_req got req=%b addr=%h exp req=1 addr=0040", icache_req, icache_addr);
    end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 16'h0040 || out_instr !== 16'h1040) begin
      fails++; $display("[TB] FAIL rdm_target_entry got valid=%b pc=%h instr=%h exp valid=1 pc=0040 instr=1040", out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_back_to_back();
    // redirect while a push and a pop both happen: redirect must win
    do_reset();
    icache_ready = 1'b1; id_ready = 1'b1;
    step(); step();
    redirect = 1'b1; redirect_pc = 16'h0020;
    step();
    redirect = 1'b0;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL b2b_flush got=%b exp=0", out_valid); end
    checks++; if (icache_req !== 1'b1 || icache_addr !== 16'h0020) begin
      fails++; $display("[TB] FAIL b2b_req got req=%b addr=%h exp req=1 addr=0020", icache_req, icache_addr);
    end
    step();
    checks++; if (out_pc !== 16'h0020 || out_pc_next !== 16'h0022) begin
      fails++; $display("[TB] FAIL b2b_entry got pc=%h next=%h exp pc=0020 next=0022", out_pc, out_pc_next);
    end
  endtask

  task automatic test_halt();
    do_reset();
    halt_en = 1'b1; icache_ready = 1'b1; id_ready = 1'b1;
    for (int k = 0; k < 5; k++) step();
    checks++; if (fetch_halted !== 1'b1) begin fails++; $display("[TB] FAIL halt_flag got=%b exp=1", fetch_halted); end
    checks++; if (icache_req !== 1'b0) begin fails++; $display("[TB] FAIL halt_no_req got=%b exp=0", icache_req); end
    checks++; if (out_valid !== 1'b1 || out_pc !== 16'h0008 || out_instr !== 16'hF000) begin
      fails++; $display("[TB] FAIL halt_entry got valid=%b pc=%h instr=%h exp valid=1 pc=0008 instr=F000", out_valid, out_pc, out_instr);
    end
    step(); step();
    checks++; if (out_valid !== 1'b0 || icache_req !== 1'b0 || fetch_halted !== 1'b1) begin
      fails++; $display("[TB] FAIL halt_drained got valid=%b req=%b halted=%b exp 0 0 1", out_valid, icache_req, fetch_halted);
    end
    redirect = 1'b1; redirect_pc = 16'h0000;
    step();
    redirect = 1'b0;
    checks++; if (fetch_halted !== 1'b0) begin fails++; $display("[TB] FAIL halt_clear got=%b exp=0", fetch_halted); end
    checks++; if (icache_req !== 1'b1 || icache_addr !== 16'h0000) begin
      fails++; $display("[TB] FAIL halt_refetch got req=%b addr=%h exp req=1 addr=0000", icache_req, icache_addr);
    end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 16'h0000) begin
      fails++; $display("[TB] FAIL halt_refetch_entry got valid=%b pc=%h exp valid=1 pc=0000", out_valid, out_pc);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    icache_ready = 1'b1; id_ready = 1'b0;
    step(); step(); step();
    checks++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL ar_pre_valid got=%b exp=1", out_valid); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL ar_valid_async got=%b exp=0", out_valid); end
    checks++; if (icache_req !== 1'b0) begin fails++; $display("[TB] FAIL ar_req_in_reset got=%b exp=0", icache_req); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL ar_ready_ignored got=%b exp=0", out_valid); end
    rst = 1'b0;
    #1;
    checks++; if (icache_req !== 1'b1 || icache_addr !== 16'h0000) begin
      fails++; $display("[TB] FAIL ar_first_req got req=%b addr=%h exp req=1 addr=0000", icache_req, icache_addr);
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc !== 16'h0000) begin
      fails++; $display("[TB] FAIL ar_first_entry got valid=%b pc=%h exp valid=1 pc=0000", out_valid, out_pc);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_miss_stall();
    test_redirect_miss();
    test_back_to_back();
    test_halt();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Parametrised instruction-fetch stage that replaces the single-register fetch path with a decoupled prefetch queue. It drives a request/ready handshake to the instruction cache, tolerating multi-cycle miss latency, and buffers up to DEPTH fetched instructions with their PCs. It stops fetching on a halt opcode and flushes cleanly on a branch redirect, including one that arrives while a cache request is outstanding. It sits between the i-cache and the IF/ID pipeline register.

## Interface
- ADDR_W, 16, PC and address width
- INSTR_W, 16, instruction width; opcode is bits [INSTR_W-1:INSTR_W-4]
- DEPTH, 4, queue entries; power of two, minimum 2
- PC_STEP, 2, sequential PC increment
- RESET_PC, 0, fetch PC after reset
- HALT_OP, 4'hF, opcode that stops fetching

- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- icache_req  out  1  fetch request; held high until accepted
- icache_addr  out  ADDR_W  address of the current request
- icache_ready  in  1  request accepted and icache_data valid this cycle; covers both hit and miss-completion
- icache_data  in  INSTR_W  fetched instruction
- redirect  in  1  taken branch; flush the queue and refetch
- redirect_pc  in  ADDR_W  redirect target
- id_ready  in  1  decode accepts the head entry; low means freeze
- out_valid  out  1  queue is non-empty
- out_instr  out  INSTR_W  head instruction
- out_pc  out  ADDR_W  head PC
- out_pc_next  out  ADDR_W  head PC + PC_STEP (modulo 2^ADDR_W)
- fetch_halted  out  1  halt opcode captured; fetch stopped

## Operation
- **State:**
  - fpc: next fetch address.
  - FSM: FETCH, DROP, HALT.
  - Circular queue of {pc, instr} with read/write pointers of log2(DEPTH) bits.
  - count: log2(DEPTH)+1 bits.
- **FETCH:**
  - icache_req = (count < DEPTH); icache_addr = fpc.
  - On icache_req & icache_ready: push {fpc, icache_data}; fpc += PC_STEP, wrapping modulo 2^ADDR_W.
  - If the pushed opcode == HALT_OP, go to HALT. The halt instruction itself is queued.
- **Request hold:** once icache_req rises, icache_req and icache_addr stay constant until icache_ready. Queue space cannot drop while a request waits, because only pops occur.
- **DROP:** entered when redirect is asserted while icache_req is high and icache_ready is low.
  - icache_req stays high with the old address.
  - On icache_ready, discard the data and go to FETCH.
- **HALT:** icache_req = 0 and fetch_halted = 1. Queued entries still drain normally.
- **Pop:** when out_valid & id_ready, advance the read pointer. A push and a pop in the same cycle leave count unchanged.
- **Redirect (highest priority):**
  - Clears the queue: count = 0, pointers = 0.
  - Sets fpc = redirect_pc.
  - Exits HALT.
  - Any same-cycle push or pop is ignored.
  - Next state:
    - From FETCH with icache_ready high: FETCH, and the accepted data is discarded.
    - From FETCH with a request pending and icache_ready low: DROP.
    - From DROP: stays DROP until ready.
    - From HALT: FETCH.
- **Output path:** out_instr, out_pc and out_pc_next come combinationally from the head entry. They are don't-care when out_valid = 0.

## Timing
- **Reset:**
  - FSM = FETCH, fpc = RESET_PC, count = 0.
  - out_valid = 0, fetch_halted = 0.
  - icache_req = 1 and icache_addr = RESET_PC from the first cycle after rst falls. While rst is high, icache_req = 0.
- **Reset mid-miss:** rst asserted while a request is pending or in DROP aborts immediately. No data is pushed, and icache_ready during rst is ignored.
- **Latency:**
  - An instruction accepted at edge N is visible on out_valid after edge N.
  - Zero-wait hits give 1 fetch per cycle.
  - A miss of M wait cycles adds M cycles.
- **Full queue:** icache_req stays low while count == DEPTH. It rises the cycle after a pop.
- **Redirect timing:** out_valid = 0 in the cycle after redirect. The first redirect-target request is issued that cycle, or after the DROP response.
- Simultaneous redirect, pop and push in one cycle: the redirect wins.

## Test plan
- **Sequential hits:** reset, icache_ready = 1, data = 16'h1000+addr, id_ready = 1.
  - out_pc runs 0,2,4,… one per cycle.
  - out_pc_next = out_pc + 2.
- **Backpressure:** id_ready = 0 with DEPTH = 4.
  - Exactly 4 requests are accepted (addrs 0,2,4,6); icache_req then falls.
  - Raising id_ready for 1 cycle pops addr 0, and the next request is addr 8.
- **Miss stall:** icache_ready held low 5 cycles on addr 4.
  - icache_req and icache_addr = 4 stay stable.
  - Entry 4 appears the cycle after ready.
  - No duplicate or skipped PCs.
- **Redirect during miss:** redirect to 16'h0040 while addr 6 is pending.
  - The addr 6 data is discarded on ready.
  - The next request is 16'h0040.
  - The queue is empty until 16'h0040 returns.
- **Halt:** data at addr 8 = 16'hF000.
  - The entry is queued and fetch_halted = 1.
  - No request for addr 10.
  - A later redirect to 0 clears fetch_halted and fetches 0.
- **Async reset mid-operation:** assert rst mid-cycle with 3 entries queued.
  - out_valid = 0 immediately, without waiting for an edge.
  - After release, the first request is addr RESET_PC.
